// File: rtl/mmio_pkg.sv
`default_nettype none
// ==== mmio_pkg : shared encodings for the MMIO UART transmitter ==== rev 1.0
package mmio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    localparam logic [11:0] DEF_TX_ADDR     = 12'hFFF;
    localparam logic [11:0] DEF_STATUS_ADDR = 12'hFFE;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_OVF     = 2;
    localparam int STAT_CNT_LSB = 4;
    localparam int STAT_CNT_W   = 5;

endpackage
`default_nettype wire

// File: rtl/mmio_uart_tx_if.sv
`default_nettype none
// ==== mmio_uart_tx_if : processor/dmem data-port bundle ==== rev 1.0
interface mmio_uart_tx_if;
    logic [11:0] address_dmem;
    logic [31:0] data;
    logic        wren;
    logic [31:0] q_ram;
    logic [31:0] q_dmem;
    logic        wren_ram;

    modport master (
        output address_dmem, data, wren, q_ram,
        input  q_dmem, wren_ram
    );

    modport slave (
        input  address_dmem, data, wren, q_ram,
        output q_dmem, wren_ram
    );
endinterface
`default_nettype wire

// File: rtl/mmio_tx_fifo.sv
`default_nettype none
// ==== mmio_tx_fifo : byte FIFO, combinational read at the read pointer ==== rev 1.0
module mmio_tx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [7:0]               din_i,
    output logic [7:0]               dout_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          wr_en, rd_en;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // A push into a full FIFO is only legal when a pop frees the slot on the same edge.
    assign wr_en = push_i & (~full_o | pop_i);
    assign rd_en = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
        if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) mem_q[wr_ptr_q] <= din_i;
    end

endmodule
`default_nettype wire

// File: rtl/mmio_uart_tx.sv
`default_nettype none
// ==== mmio_uart_tx : dmem-port MMIO UART transmitter, 8N1 with byte FIFO ==== rev 1.0
module mmio_uart_tx
    import mmio_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 434,
    parameter int          FIFO_DEPTH   = 16,
    parameter logic [11:0] TX_ADDR      = DEF_TX_ADDR,
    parameter logic [11:0] STATUS_ADDR  = DEF_STATUS_ADDR
) (
    input  logic           clock,
    input  logic           reset,
    mmio_uart_tx_if.slave  bus,
    output logic           uart_tx,
    output logic           tx_busy
);
    localparam int            BW       = $clog2(CLKS_PER_BIT);
    localparam int            CW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

    logic          hit_tx, hit_st, push, clr_ovf;
    logic          fifo_pop, fifo_full, fifo_empty;
    logic [7:0]    fifo_dout;
    logic [CW-1:0] fifo_count;
    logic [31:0]   status;
    logic          unused_data_hi;

    tx_state_e     state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          ovf_q, ovf_d;
    logic          baud_last;

    assign hit_tx  = (bus.address_dmem == TX_ADDR);
    assign hit_st  = (bus.address_dmem == STATUS_ADDR);
    assign push    = bus.wren & hit_tx;
    assign clr_ovf = bus.wren & hit_st;
    assign unused_data_hi = ^bus.data[31:8];

    assign bus.wren_ram = bus.wren & ~hit_tx & ~hit_st;
    assign bus.q_dmem   = hit_st ? status : bus.q_ram;

    assign tx_busy = (state_q != ST_IDLE) | (fifo_count != '0);
    assign uart_tx = tx_q;

    always_comb begin
        status = '0;
        status[STAT_BUSY] = tx_busy;
        status[STAT_FULL] = fifo_full;
        status[STAT_OVF]  = ovf_q;
        status[STAT_CNT_LSB +: STAT_CNT_W] = STAT_CNT_W'(fifo_count);
    end

    // A fresh overflow on the clearing edge takes priority over the clear.
    assign ovf_d = (push & fifo_full & ~fifo_pop) | (ovf_q & ~clr_ovf);

    mmio_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (fifo_pop),
        .din_i   (bus.data[7:0]),
        .dout_o  (fifo_dout),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign baud_last = (baud_q == BAUD_MAX);

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        fifo_pop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = ST_DATA;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            ST_DATA: begin
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        bit_d   = '0;
                        state_d = ST_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            ST_STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_dout;
                        state_d  = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Line level is registered from the next state so the pin never glitches.
        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
`default_nettype none
// ==== tb_mmio_uart_tx : directed bench with frame-level reference model ==== rev 1.0
module tb_mmio_uart_tx;
    localparam int          CPB   = 4;
    localparam int          DEPTH = 4;
    localparam int          FRAME = 10 * CPB;
    localparam logic [11:0] A_TX  = 12'hFFF;
    localparam logic [11:0] A_ST  = 12'hFFE;
    localparam logic [11:0] A_NEU = 12'h020;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic uart_tx, tx_busy;

    always #5 clock = ~clock;

    mmio_uart_tx_if bus_if ();

    mmio_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .TX_ADDR      (A_TX),
        .STATUS_ADDR  (A_ST)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .bus     (bus_if.slave),
        .uart_tx (uart_tx),
        .tx_busy (tx_busy)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a byte queue plus the cycle offset into the frame on the wire (-1 = line idle).
    byte unsigned m_q[$];
    int           m_t   = -1;
    logic [7:0]   m_cur = '0;
    bit           m_ovf = 1'b0;
    bit           m_pop, m_push, m_new_ovf;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_q.delete();
            m_t   = -1;
            m_ovf = 1'b0;
        end else begin
            m_pop     = (m_q.size() > 0) && (m_t < 0 || m_t == FRAME - 1);
            m_push    = bus_if.wren && (bus_if.address_dmem == A_TX);
            m_new_ovf = m_push && (m_q.size() == DEPTH) && !m_pop;
            if (m_pop) begin
                m_cur = m_q.pop_front();
                m_t   = 0;
            end else if (m_t >= 0) begin
                m_t++;
                if (m_t == FRAME) m_t = -1;
            end
            if (m_push && !m_new_ovf) m_q.push_back(bus_if.data[7:0]);
            if (m_new_ovf) m_ovf = 1'b1;
            else if (bus_if.wren && bus_if.address_dmem == A_ST) m_ovf = 1'b0;
        end
    end

    function automatic logic m_line();
        int slot;
        if (m_t < 0) return 1'b1;
        slot = m_t / CPB;
        if (slot == 0) return 1'b0;
        if (slot == 9) return 1'b1;
        return m_cur[slot-1];
    endfunction

    function automatic logic m_busy();
        return (m_t >= 0) || (m_q.size() > 0);
    endfunction

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s      = 32'(m_q.size()) << 4;
        s[2]   = m_ovf;
        s[1]   = (m_q.size() == DEPTH);
        s[0]   = m_busy();
        return s;
    endfunction

    always @(negedge clock) begin
        chk("uart_tx", {31'b0, uart_tx}, {31'b0, m_line()});
        chk("tx_busy", {31'b0, tx_busy}, {31'b0, m_busy()});
        chk("wren_ram", {31'b0, bus_if.wren_ram},
            {31'b0, bus_if.wren && bus_if.address_dmem != A_TX && bus_if.address_dmem != A_ST});
        chk("q_dmem", bus_if.q_dmem,
            (bus_if.address_dmem == A_ST) ? m_status() : bus_if.q_ram);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic store(input logic [11:0] a, input logic [31:0] d);
        bus_if.address_dmem = a;
        bus_if.data         = d;
        bus_if.wren         = 1'b1;
        tick(1);
        bus_if.wren         = 1'b0;
        bus_if.address_dmem = A_NEU;
        bus_if.data         = '0;
    endtask

    task automatic read_status(input string name, input logic [31:0] exp);
        bus_if.address_dmem = A_ST;
        #1;
        chk(name, bus_if.q_dmem, exp);
        bus_if.address_dmem = A_NEU;
    endtask

    logic [9:0] exp55 = 10'b1010101010;

    initial begin
        bus_if.address_dmem = A_NEU;
        bus_if.data         = '0;
        bus_if.wren         = 1'b0;
        bus_if.q_ram        = 32'hCAFE_0001;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;

        chk("reset_uart_tx", {31'b0, uart_tx}, 32'd1);
        chk("reset_tx_busy", {31'b0, tx_busy}, 32'd0);
        read_status("reset_status", 32'h0);

        // Single 0x55 frame, upper data bits ignored.
        bus_if.address_dmem = A_TX;
        bus_if.data         = 32'h0000_0155;
        bus_if.wren         = 1'b1;
        #1 chk("tx_store_wren_ram", {31'b0, bus_if.wren_ram}, 32'd0);
        tick(1);
        bus_if.wren = 1'b0;
        bus_if.address_dmem = A_NEU;
        tick(1);
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("frame55_bit%0d", k), {31'b0, uart_tx}, {31'b0, exp55[k]});
            tick(CPB);
        end
        chk("frame55_done_busy", {31'b0, tx_busy}, 32'd0);

        // Pass-through access.
        bus_if.address_dmem = 12'h010;
        bus_if.data         = 32'h1234_5678;
        bus_if.wren         = 1'b1;
        #1 chk("pass_wren_ram", {31'b0, bus_if.wren_ram}, 32'd1);
        tick(1);
        bus_if.wren  = 1'b0;
        bus_if.q_ram = 32'hDEAD_BEEF;
        #1 chk("pass_q_dmem", bus_if.q_dmem, 32'hDEAD_BEEF);
        chk("pass_uart_idle", {31'b0, uart_tx}, 32'd1);
        bus_if.address_dmem = A_NEU;
        tick(2);

        // Two back-to-back frames.
        store(A_TX, 32'h41);
        store(A_TX, 32'h42);
        read_status("two_count1", 32'h11);
        tick(41);
        read_status("two_count0", 32'h01);
        tick(39);
        chk("two_done_busy", {31'b0, tx_busy}, 32'd0);

        // Overflow: six pushes into a depth-4 FIFO.
        for (int i = 0; i < 6; i++) store(A_TX, 32'h60 + i);
        read_status("ovf_status", 32'h47);
        store(A_ST, 32'hFFFF_FFFF);
        read_status("ovf_cleared", 32'h43);
        tick(5 * FRAME + 5);
        chk("ovf_drain_busy", {31'b0, tx_busy}, 32'd0);

        // Reset in the middle of the DATA phase with two bytes queued.
        store(A_TX, 32'h81);
        store(A_TX, 32'h82);
        store(A_TX, 32'h83);
        tick(8);
        chk("pre_reset_line_low", {31'b0, uart_tx}, 32'd0);
        reset = 1'b0;
        #1 chk("midreset_uart_tx", {31'b0, uart_tx}, 32'd1);
        chk("midreset_busy", {31'b0, tx_busy}, 32'd0);
        @(posedge clock);
        #1 reset = 1'b1;
        read_status("postreset_status", 32'h0);
        tick(60);

        // Push into a full FIFO on the STOP-to-START pop edge.
        for (int i = 0; i < 5; i++) store(A_TX, 32'hA1 + i);
        tick(36);
        store(A_TX, 32'hA6);
        read_status("fullpop_status", 32'h43);
        tick(5 * FRAME + 5);
        chk("fullpop_drain_busy", {31'b0, tx_busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
